time_keep_ctrl: RTL and testbench

//  Sequencer for the clock's time datapath: owns the second/minute/hour counters and the

---
 rtl/time_keep_ctrl_pkg.sv | 21 ++
 rtl/time_keep_ctrl_if.sv | 22 ++
 rtl/time_keep_ctrl_prescaler.sv | 36 +++
 rtl/time_keep_ctrl.sv | 99 +++++++++
 tb/tb_time_keep_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/time_keep_ctrl_pkg.sv
// Shared definitions for the time-keeping datapath: set-mode states and field limits.
// State encoding doubles as the set_field display-blink select.
package time_keep_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10,
        SET_S = 2'b11
    } state_e;

    localparam logic [7:0] SEC_MAX  = 8'd59;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    localparam logic [7:0] HOUR_MAX = 8'd23;

    // Increment with wrap to zero once the field limit is reached.
    function automatic logic [7:0] wrap_inc(input logic [7:0] val, input logic [7:0] lim);
        return (val >= lim) ? 8'd0 : val + 8'd1;
    endfunction

endpackage

// File: rtl/time_keep_ctrl_if.sv
// Button-pulse inputs and time/strobe outputs of the time-keeping sequencer.
// master = button front-end / observer side, slave = time_keep_ctrl.
interface time_keep_ctrl_if;
    logic       mode_p;
    logic       inc_p;
    logic [7:0] second;
    logic [7:0] minute;
    logic [7:0] hour;
    logic       m_bit;
    logic       h_bit;
    logic [1:0] set_field;

    modport master (
        output mode_p, inc_p,
        input  second, minute, hour, m_bit, h_bit, set_field
    );

    modport slave (
        input  mode_p, inc_p,
        output second, minute, hour, m_bit, h_bit, set_field
    );
endinterface

// File: rtl/time_keep_ctrl_prescaler.sv
// 1 s tick generator: counts 0..TICK_DIV-1 while enabled, held at zero otherwise.
// Shared with the alarm block.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000,
    parameter int TICK_W   = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [TICK_W-1:0] TERM = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;

    assign tick = en && (cnt_q == TERM);

    // Disabling clears the count so a re-enabled period is always a full TICK_DIV cycles.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/time_keep_ctrl.sv
// Time sequencer: second/minute/hour counters, registered carry strobes and the
// RUN -> SET_H -> SET_M -> SET_S set-mode FSM.
module time_keep_ctrl
    import time_keep_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int TICK_W   = 26
) (
    input  logic            clk,
    input  logic            rst_n,
    time_keep_ctrl_if.slave tk
);

    state_e     state_q;
    logic [7:0] sec_q;
    logic [7:0] min_q;
    logic [7:0] hour_q;
    logic       m_bit_q;
    logic       h_bit_q;
    logic       tick;
    logic       run_en;

    assign run_en = (state_q == RUN);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run_en),
        .tick  (tick)
    );

    // Strobes are set on the same edge the wrapped field lands, so they line up with second==0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            m_bit_q <= 1'b0;
            h_bit_q <= 1'b0;
        end else begin
            m_bit_q <= 1'b0;
            h_bit_q <= 1'b0;
            unique case (state_q)
                RUN: begin
                    if (tick) begin
                        if (sec_q >= SEC_MAX) begin
                            sec_q   <= '0;
                            min_q   <= wrap_inc(min_q, MIN_MAX);
                            m_bit_q <= 1'b1;
                            if (min_q >= MIN_MAX) begin
                                hour_q  <= wrap_inc(hour_q, HOUR_MAX);
                                h_bit_q <= 1'b1;
                            end
                        end else begin
                            sec_q <= sec_q + 8'd1;
                        end
                    end
                    if (tk.mode_p) begin
                        state_q <= SET_H;
                    end
                end
                SET_H: begin
                    if (tk.mode_p) begin
                        state_q <= SET_M;
                    end else if (tk.inc_p) begin
                        hour_q <= wrap_inc(hour_q, HOUR_MAX);
                    end
                end
                SET_M: begin
                    if (tk.mode_p) begin
                        state_q <= SET_S;
                    end else if (tk.inc_p) begin
                        min_q <= wrap_inc(min_q, MIN_MAX);
                    end
                end
                SET_S: begin
                    if (tk.mode_p) begin
                        state_q <= RUN;
                    end else if (tk.inc_p) begin
                        sec_q <= wrap_inc(sec_q, SEC_MAX);
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign tk.second    = sec_q;
    assign tk.minute    = min_q;
    assign tk.hour      = hour_q;
    assign tk.m_bit     = m_bit_q;
    assign tk.h_bit     = h_bit_q;
    assign tk.set_field = state_q;

endmodule

// File: tb/tb_time_keep_ctrl.sv
// Bench for time_keep_ctrl: directed scenarios plus random button traffic, each cycle
// checked against a seconds-of-day reference model.
module tb_time_keep_ctrl;

    localparam int TICK_DIV = 4;
    localparam int TICK_W   = 2;

    logic clk;
    logic rst_n;

    time_keep_ctrl_if tk ();

    time_keep_ctrl #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tk    (tk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: time as seconds since midnight, field = 0 RUN / 1 hour / 2 minute / 3 second.
    int t_ref;
    int fld_ref;
    int phase_ref;
    int m_ref;
    int h_ref;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".second"},    32'(tk.second),    t_ref % 60);
        check({tag, ".minute"},    32'(tk.minute),    (t_ref / 60) % 60);
        check({tag, ".hour"},      32'(tk.hour),      t_ref / 3600);
        check({tag, ".m_bit"},     32'(tk.m_bit),     m_ref);
        check({tag, ".h_bit"},     32'(tk.h_bit),     h_ref);
        check({tag, ".set_field"}, 32'(tk.set_field), fld_ref);
    endtask

    task automatic model_reset();
        t_ref     = 0;
        fld_ref   = 0;
        phase_ref = 0;
        m_ref     = 0;
        h_ref     = 0;
    endtask

    task automatic model_step(input bit mode, input bit inc);
        int hh, mm, ss;
        m_ref = 0;
        h_ref = 0;
        hh = t_ref / 3600;
        mm = (t_ref / 60) % 60;
        ss = t_ref % 60;
        if (fld_ref == 0) begin
            if (phase_ref == TICK_DIV - 1) begin
                phase_ref = 0;
                t_ref = (t_ref + 1) % 86400;
                if (t_ref % 60 == 0)   m_ref = 1;
                if (t_ref % 3600 == 0) h_ref = 1;
            end else begin
                phase_ref++;
            end
            if (mode) fld_ref = 1;
        end else begin
            phase_ref = 0;
            if (mode) begin
                fld_ref = (fld_ref + 1) % 4;
            end else if (inc) begin
                case (fld_ref)
                    1: hh = (hh + 1) % 24;
                    2: mm = (mm + 1) % 60;
                    default: ss = (ss + 1) % 60;
                endcase
                t_ref = hh * 3600 + mm * 60 + ss;
            end
        end
    endtask

    task automatic step(input bit mode, input bit inc);
        tk.mode_p = mode;
        tk.inc_p  = inc;
        @(posedge clk);
        if (rst_n) model_step(mode, inc);
        #1;
        tk.mode_p = 1'b0;
        tk.inc_p  = 1'b0;
        check_all("model");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    // Walks the set-mode FSM from RUN, landing on hh:mm:ss and back in RUN.
    task automatic preset(input int hh, input int mm, input int ss);
        step(1'b1, 1'b0);
        incs((hh - t_ref / 3600 + 24) % 24);
        step(1'b1, 1'b0);
        incs((mm - (t_ref / 60) % 60 + 60) % 60);
        step(1'b1, 1'b0);
        incs((ss - t_ref % 60 + 60) % 60);
        step(1'b1, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        tk.mode_p = 1'b0;
        tk.inc_p  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: reset mid-count, then first full period yields second=1
        idle(6);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all("rst_hold");
        end
        rst_n = 1'b1;
        idle(3);
        check("t1.second_before_tick", 32'(tk.second), 0);
        idle(1);
        check("t1.second_first_tick", 32'(tk.second), 1);

        // 2: 00:00:58 -> 59 -> 00:01:00 with single-cycle m_bit
        preset(0, 0, 58);
        idle(4);
        check("t2.second_59", 32'(tk.second), 59);
        idle(4);
        check("t2.second_wrap", 32'(tk.second), 0);
        check("t2.minute", 32'(tk.minute), 1);
        check("t2.m_bit_high", 32'(tk.m_bit), 1);
        check("t2.h_bit_low", 32'(tk.h_bit), 0);
        idle(1);
        check("t2.m_bit_one_clk", 32'(tk.m_bit), 0);

        // 3: 23:59:59 -> 00:00:00 with both strobes together
        preset(23, 59, 59);
        idle(4);
        check("t3.hour", 32'(tk.hour), 0);
        check("t3.minute", 32'(tk.minute), 0);
        check("t3.second", 32'(tk.second), 0);
        check("t3.m_bit", 32'(tk.m_bit), 1);
        check("t3.h_bit", 32'(tk.h_bit), 1);
        idle(1);
        check("t3.m_bit_drop", 32'(tk.m_bit), 0);
        check("t3.h_bit_drop", 32'(tk.h_bit), 0);

        // 4: hour increments 25 times, wrapping through 23 -> 0
        step(1'b1, 1'b0);
        incs(25);
        check("t4.hour", 32'(tk.hour), 1);
        check("t4.set_field", 32'(tk.set_field), 1);
        check("t4.second_frozen", 32'(tk.second), 0);
        idle(6);
        check("t4.second_still_frozen", 32'(tk.second), 0);

        // 5: mode_p wins over inc_p
        step(1'b1, 1'b1);
        check("t5.set_field", 32'(tk.set_field), 2);
        check("t5.hour_unchanged", 32'(tk.hour), 1);

        // 6: reset during SET_M with minute=37
        incs(37);
        check("t6.minute_37", 32'(tk.minute), 37);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6.hour", 32'(tk.hour), 0);
        check("t6.minute", 32'(tk.minute), 0);
        check("t6.set_field", 32'(tk.set_field), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        check("t6.run_after_release", 32'(tk.second), 1);

        // Random button traffic, occasionally jumping near a carry boundary
        for (int r = 0; r < 400; r++) begin
            if (r % 100 == 50 && fld_ref == 0) begin
                preset($urandom_range(23, 0), 59, $urandom_range(59, 57));
            end else begin
                step(($urandom % 12) == 0, ($urandom % 3) == 0);
            end
        end
        if (fld_ref != 0) begin
            while (fld_ref != 0) step(1'b1, 1'b0);
        end
        idle(TICK_DIV * 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
